// File: rtl/instr_fetch_if.sv
// Instruction-memory port of the fetch unit: req/gnt request channel and
// in-order rvalid/rdata response channel.
//   instr_req    - request valid (fetch side)
//   instr_addr   - word-aligned fetch address (fetch side)
//   instr_gnt    - request accepted this cycle (memory side)
//   instr_rvalid - response valid, in request order (memory side)
//   instr_rdata  - response data (memory side)
interface instr_fetch_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;

  modport master (
    output instr_req,
    output instr_addr,
    input  instr_gnt,
    input  instr_rvalid,
    input  instr_rdata
  );

  modport slave (
    input  instr_req,
    input  instr_addr,
    output instr_gnt,
    output instr_rvalid,
    output instr_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit. Issues sequential word fetches on the instruction
// memory port, buffers responses with their PCs in a prefetch FIFO and hands
// them to the decoder. A redirect flushes the FIFO, restarts fetching at the
// target and discards every response still owed to the old stream.
//   clk_i, rst_ni    - clock, asynchronous active-low reset
//   mem              - instruction memory port (master side)
//   redirect_i       - one-cycle jump/branch pulse
//   redirect_addr_i  - new PC (bits [1:0] ignored)
//   instr_valid_o    - instr_o/instr_pc_o valid
//   instr_o          - instruction to the decoder
//   instr_pc_o       - PC of instr_o
//   instr_ready_i    - decoder accepts the head entry
module instr_fetch #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  instr_fetch_if.master       mem,
  input  logic                redirect_i,
  input  logic [31:0]         redirect_addr_i,
  output logic                instr_valid_o,
  output logic [31:0]         instr_o,
  output logic [31:0]         instr_pc_o,
  input  logic                instr_ready_i
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t DepthCnt = cnt_t'(FIFO_DEPTH);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  cnt_t        outst_q, outst_d;
  cnt_t        disc_q, disc_d;
  cnt_t        occ_q, occ_d;
  ptr_t        wptr_q, wptr_d;
  ptr_t        rptr_q, rptr_d;
  ptr_t        qw_q, qw_d;
  ptr_t        qr_q, qr_d;

  logic [31:0] pcq_q  [FIFO_DEPTH];  // PCs of granted requests awaiting rvalid
  logic [31:0] data_q [FIFO_DEPTH];
  logic [31:0] pc_q   [FIFO_DEPTH];

  logic        grant, hold, rvalid_eff, drop, push, pop, issue;
  logic [31:0] target, base_pc;
  logic [CntW:0] credit;

  assign instr_valid_o  = (occ_q != '0) & ~redirect_i;
  assign instr_o        = data_q[rptr_q];
  assign instr_pc_o     = pc_q[rptr_q];
  assign mem.instr_req  = req_q;
  assign mem.instr_addr = addr_q;

  always_comb begin
    grant      = req_q & mem.instr_gnt;
    hold       = req_q & ~mem.instr_gnt;
    // A stray rvalid with nothing outstanding is ignored.
    rvalid_eff = mem.instr_rvalid & (outst_q != '0);
    // A response arriving with a redirect belongs to the old stream.
    drop       = rvalid_eff & ((disc_q != '0) | redirect_i);
    push       = rvalid_eff & ~drop;
    pop        = instr_valid_o & instr_ready_i;
    target     = redirect_addr_i & 32'hFFFF_FFFC;

    outst_d = outst_q + cnt_t'(grant) - cnt_t'(rvalid_eff);
    qw_d    = qw_q + ptr_t'(grant);
    qr_d    = qr_q + ptr_t'(rvalid_eff);
    rptr_d  = rptr_q + ptr_t'(pop);

    if (redirect_i) begin
      occ_d  = '0;
      wptr_d = rptr_q;
    end else begin
      occ_d  = occ_q + cnt_t'(push) - cnt_t'(pop);
      wptr_d = wptr_q + ptr_t'(push);
    end

    // Everything still in flight after this cycle, including an ungranted
    // request, is stale once a redirect is taken.
    disc_d = disc_q;
    if (redirect_i) begin
      disc_d = outst_d + cnt_t'(hold);
    end else if (rvalid_eff && (disc_q != '0)) begin
      disc_d = disc_q - cnt_t'(1);
    end

    // Credit is checked against next-cycle state so a granted request is
    // already counted when the following one is decided.
    credit  = {1'b0, occ_d} + {1'b0, outst_d};
    base_pc = redirect_i ? target : fetch_pc_q;
    issue   = ~hold & (credit < {1'b0, DepthCnt});

    req_d      = hold | issue;
    addr_d     = issue ? base_pc : addr_q;
    fetch_pc_d = issue ? base_pc + 32'd4 : base_pc;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= BOOT_ADDR;
      req_q      <= 1'b0;
      addr_q     <= BOOT_ADDR;
      outst_q    <= '0;
      disc_q     <= '0;
      occ_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      qw_q       <= '0;
      qr_q       <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        pcq_q[i]  <= '0;
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      occ_q      <= occ_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      qw_q       <= qw_d;
      qr_q       <= qr_d;
      if (grant) begin
        pcq_q[qw_q] <= addr_q;
      end
      if (push) begin
        data_q[wptr_q] <= mem.instr_rdata;
        pc_q[wptr_q]   <= pcq_q[qr_q];
      end
    end
  end

  rvalid_with_outstanding: assert property (
    @(posedge clk_i) disable iff (!rst_ni) mem.instr_rvalid |-> (outst_q != '0)
  );

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam logic [31:0] Boot  = 32'h0000_0100;
  localparam int unsigned Depth = 4;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  instr_fetch_if mem_if ();

  instr_fetch #(
    .BOOT_ADDR  (Boot),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .mem             (mem_if),
    .redirect_i      (redirect),
    .redirect_addr_i (redirect_addr),
    .instr_valid_o   (instr_valid),
    .instr_o         (instr),
    .instr_pc_o      (instr_pc),
    .instr_ready_i   (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned gnt_pct, rv_pct, rdy_pct;
  logic        redir_req;
  logic [31:0] redir_target;
  logic [31:0] gq[$];      // addresses granted, response not yet returned
  logic [31:0] popped[$];  // PCs delivered to the decoder
  logic [31:0] exp_pc;     // next PC the decoder must see
  logic        prev_hold;
  logic [31:0] prev_addr;
  int          n_pops;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic neutral();
    mem_if.instr_gnt    = 1'b0;
    mem_if.instr_rvalid = 1'b0;
    mem_if.instr_rdata  = 32'h0;
    redirect            = 1'b0;
    redirect_addr       = 32'h0;
    instr_ready         = 1'b0;
  endtask

  // One clock cycle: drive memory/consumer inputs, check against the model,
  // advance the model, then move to just after the next rising edge.
  task automatic step();
    logic        do_r;
    logic [31:0] tgt;
    logic [31:0] a;
    mem_if.instr_gnt = ($urandom_range(99) < gnt_pct);
    if (gq.size() != 0 && $urandom_range(99) < rv_pct) begin
      a = gq.pop_front();
      mem_if.instr_rvalid = 1'b1;
      mem_if.instr_rdata  = mem_word(a);
    end else begin
      mem_if.instr_rvalid = 1'b0;
      mem_if.instr_rdata  = $urandom;
    end
    instr_ready   = ($urandom_range(99) < rdy_pct);
    do_r          = redir_req;
    tgt           = redir_target;
    redir_req     = 1'b0;
    redirect      = do_r;
    redirect_addr = tgt;
    #1;
    if (prev_hold) begin
      check_eq("hold_req", {31'b0, mem_if.instr_req}, 32'd1);
      check_eq("hold_addr", mem_if.instr_addr, prev_addr);
    end
    if (do_r) check_eq("valid_during_redirect", {31'b0, instr_valid}, 32'd0);
    if (instr_valid && instr_ready) begin
      check_eq("pop_pc", instr_pc, exp_pc);
      check_eq("pop_instr", instr, mem_word(exp_pc));
      popped.push_back(instr_pc);
      exp_pc = exp_pc + 32'd4;
      n_pops++;
    end
    if (do_r) exp_pc = {tgt[31:2], 2'b00};
    if (mem_if.instr_req && mem_if.instr_gnt) begin
      gq.push_back(mem_if.instr_addr);
      check_eq("outstanding_bound", {31'b0, gq.size() <= Depth}, 32'd1);
      check_eq("addr_aligned", {30'b0, mem_if.instr_addr[1:0]}, 32'd0);
    end
    prev_hold = mem_if.instr_req & ~mem_if.instr_gnt;
    prev_addr = mem_if.instr_addr;
    @(posedge clk);
    #1;
    neutral();
  endtask

  task automatic set_pct(input int unsigned g, input int unsigned v, input int unsigned r);
    gnt_pct = g;
    rv_pct  = v;
    rdy_pct = r;
  endtask

  initial begin
    logic [31:0] a0;
    logic        found;
    int          pops_before;
    rst_n        = 1'b0;
    redir_req    = 1'b0;
    redir_target = 32'h0;
    prev_hold    = 1'b0;
    prev_addr    = 32'h0;
    exp_pc       = Boot;
    n_pops       = 0;
    neutral();
    set_pct(100, 100, 100);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req", {31'b0, mem_if.instr_req}, 32'd0);
    check_eq("rst_addr", mem_if.instr_addr, Boot);
    check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("rst_instr", instr, 32'd0);
    check_eq("rst_pc", instr_pc, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Boot: back-to-back fetches from Boot, first delivery in cycle 3
    for (int k = 1; k <= 8; k++) begin
      check_eq("boot_req", {31'b0, mem_if.instr_req}, 32'd1);
      check_eq("boot_addr", mem_if.instr_addr, Boot + 32'(4 * (k - 1)));
      if (k >= 3) begin
        check_eq("boot_valid", {31'b0, instr_valid}, 32'd1);
        check_eq("boot_pc", instr_pc, Boot + 32'(4 * (k - 3)));
      end
      step();
    end

    // Backpressure: requests stop once the FIFO and outstanding fill
    set_pct(100, 100, 0);
    repeat (10) step();
    check_eq("bp_req_stopped", {31'b0, mem_if.instr_req}, 32'd0);
    check_eq("bp_valid", {31'b0, instr_valid}, 32'd1);
    check_eq("bp_head_pc", instr_pc, exp_pc);
    set_pct(100, 100, 100);
    repeat (8) step();

    // Grant stall: request and address hold until granted
    a0 = mem_if.instr_addr;
    check_eq("stall_req_start", {31'b0, mem_if.instr_req}, 32'd1);
    set_pct(0, 100, 100);
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("stall_req", {31'b0, mem_if.instr_req}, 32'd1);
      check_eq("stall_addr", mem_if.instr_addr, a0);
    end
    set_pct(100, 100, 100);
    step();
    check_eq("stall_next_addr", mem_if.instr_addr, a0 + 32'd4);

    // Redirect with requests outstanding
    set_pct(0, 100, 100);
    repeat (4) step();
    set_pct(100, 0, 100);
    repeat (2) step();
    redir_req    = 1'b1;
    redir_target = 32'h0000_2002;
    step();
    check_eq("redir_req", {31'b0, mem_if.instr_req}, 32'd1);
    check_eq("redir_addr", mem_if.instr_addr, 32'h0000_2000);
    check_eq("redir_flushed", {31'b0, instr_valid}, 32'd0);
    set_pct(100, 100, 100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (instr_valid) begin
        found = 1'b1;
        check_eq("redir_first_pc", instr_pc, 32'h0000_2000);
      end else begin
        step();
      end
    end
    check_eq("redir_delivered", {31'b0, found}, 32'd1);
    repeat (4) step();

    // Redirect while a request is pending ungranted
    set_pct(0, 100, 100);
    repeat (4) step();
    a0           = mem_if.instr_addr;
    redir_req    = 1'b1;
    redir_target = 32'h0000_3000;
    step();
    check_eq("pend_req", {31'b0, mem_if.instr_req}, 32'd1);
    check_eq("pend_addr_held", mem_if.instr_addr, a0);
    set_pct(100, 100, 100);
    step();
    check_eq("pend_then_target", mem_if.instr_addr, 32'h0000_3000);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (instr_valid) begin
        found = 1'b1;
        check_eq("pend_first_pc", instr_pc, 32'h0000_3000);
      end else begin
        step();
      end
    end
    check_eq("pend_delivered", {31'b0, found}, 32'd1);

    // Address wrap
    popped.delete();
    redir_req    = 1'b1;
    redir_target = 32'hFFFF_FFF9;
    step();
    repeat (12) step();
    check_eq("wrap_count", {31'b0, popped.size() >= 4}, 32'd1);
    begin
      logic [31:0] wrap_exp [4];
      wrap_exp[0] = 32'hFFFF_FFF8;
      wrap_exp[1] = 32'hFFFF_FFFC;
      wrap_exp[2] = 32'h0000_0000;
      wrap_exp[3] = 32'h0000_0004;
      for (int i = 0; i < 4; i++) begin
        if (i < popped.size()) check_eq("wrap_pc", popped[i], wrap_exp[i]);
      end
    end

    // Random traffic with random redirects
    for (int c = 0; c < 2000; c++) begin
      if (c % 100 == 0) begin
        set_pct($urandom_range(20, 100), $urandom_range(20, 100), $urandom_range(10, 100));
      end
      if ($urandom_range(99) < 4) begin
        redir_req    = 1'b1;
        redir_target = $urandom;
      end
      step();
    end

    // Drain: the stream must keep flowing
    set_pct(100, 100, 100);
    pops_before = n_pops;
    repeat (30) step();
    check_eq("drain_progress", {31'b0, n_pops > pops_before + 20}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_checks, n_errors);
    $finish;
  end

endmodule
